usb_in_ep_pingpong_buf: RTL and testbench
=========================================

// Module: usb_in_ep_pingpong_buf
// PURPOSE
//  Multi-endpoint, double-buffered (ping-pong) IN packet buffer between the application-side
//  buf_in_* write port and the USB protocol engine. Replaces the single-bank, single-endpoint
//  IN buffer. Each endpoint has two banks, so the app fills one packet while the engine
//  transmits or retries the other. Packets are held until the engine reports host ACK.
// PARAMETERS
//  NUM_EP  4  number of IN endpoints (1..16)
//  DATA_W  8  buffer data width, bits
//  ADDR_W  9  byte address width per bank; bank depth = 2**ADDR_W
//  LEN_W   10 packet length width; must equal ADDR_W+1
// PORTS
//  phy_ulpi_clk       in   1            sole clock, rising edge
//  reset_n            in   1            asynchronous active-low reset
//  buf_in_ep          in   EPW          app endpoint select; EPW = max(1,$clog2(NUM_EP))
//  buf_in_addr        in   ADDR_W       app write byte address within the current fill bank
//  buf_in_data        in   DATA_W       app write data
//  buf_in_wren        in   1            app write strobe
//  buf_in_commit      in   1            app pulse: fill bank of buf_in_ep holds a complete packet
//  buf_in_commit_len  in   LEN_W        packet length in bytes, sampled with buf_in_commit
//  buf_in_ready       out  NUM_EP       bit e = endpoint e has a free bank to fill
//  buf_in_commit_ack  out  1            1-cycle pulse: commit accepted
//  err_commit_ovf     out  1            1-cycle pulse: commit rejected, endpoint full
//  pe_rd_ep           in   EPW          engine endpoint select
//  pe_rd_addr         in   ADDR_W       engine read byte address within head bank
//  pe_rd_data         out  DATA_W       read data, registered
//  pe_has_pkt         out  NUM_EP       bit e = endpoint e holds >=1 committed packet
//  pe_pkt_len         out  LEN_W        length of head packet of pe_rd_ep (0 if none)
//  pe_done            in   1            engine pulse: head packet of pe_rd_ep ACKed, release it
//  ep_flush           in   NUM_EP       per-endpoint synchronous flush
// BEHAVIOUR
//  Per-endpoint state: wr_bank, rd_bank (1 bit each), cnt in {0,1,2}, len[2] (LEN_W each).
//  Storage: one RAM of NUM_EP*2*2**ADDR_W words, word address {ep, bank, addr}.
//  - Reset: cnt=0, wr_bank=rd_bank=0, len=0 for every endpoint. buf_in_ready all ones,
//    pe_has_pkt=0, pe_pkt_len=0, pe_rd_data=0, buf_in_commit_ack=0, err_commit_ovf=0.
//  - buf_in_ready[e] = (cnt[e]!=2). pe_has_pkt[e] = (cnt[e]!=0). Both come from registers.
//  - Write: wren with cnt[buf_in_ep]!=2 writes {buf_in_ep, wr_bank, buf_in_addr}. A write to a
//    full endpoint is dropped.
//  - Commit is accepted when cnt!=2, or when cnt==2 and pe_done releases the same endpoint in
//    the same cycle. On accept: len[wr_bank] is loaded, wr_bank toggles, cnt increments, and
//    buf_in_commit_ack pulses the next cycle. On reject: state is unchanged and
//    err_commit_ovf pulses the next cycle.
//  - commit_len > 2**ADDR_W is saturated to 2**ADDR_W. A length of 0 is legal (ZLP).
//  - Read: pe_rd_data <= RAM[{pe_rd_ep, rd_bank[pe_rd_ep], pe_rd_addr}]. Latency is 1 cycle.
//    Reads do not consume data; the engine re-reads the same packet for retries.
//  - pe_pkt_len = len[rd_bank[pe_rd_ep]] when cnt!=0, else 0. This is combinational from
//    registers.
//  - pe_done with cnt[pe_rd_ep]!=0: rd_bank toggles and cnt decrements. With cnt==0 it is
//    ignored.
//  - Commit and done on the same endpoint in the same cycle: both pointers toggle and cnt is
//    unchanged.
//  - Commit and done on different endpoints in the same cycle: each is applied independently.
//  - ep_flush[e]: cnt=0, wr_bank=rd_bank=0. It overrides any write, commit or done on e in the
//    same cycle; a commit on e that cycle gets no ack and no err. Other endpoints are unaffected.
//  - buf_in_ep or pe_rd_ep >= NUM_EP: write, commit and done are ignored, pe_pkt_len=0, and
//    pe_rd_data holds its value.
//  - Async reset mid-packet discards all buffered packets. RAM contents are don't-care.
// TESTING
//  1 Reset -> buf_in_ready=4'hF, pe_has_pkt=0, pe_pkt_len=0, acks low.
//  2 EP1: write 64 bytes 0x00..0x3F, commit len=64 -> ack 1 cycle later. pe_has_pkt=4'b0010,
//    pe_pkt_len=64. pe_rd_ep=1, addr 5 -> pe_rd_data=0x05 one cycle later.
//  3 EP2: commit 3 packets without done -> 2 acks, then err_commit_ovf and buf_in_ready[2]=0.
//    pe_done -> ready[2]=1, head len is the 2nd packet's.
//  4 EP0 cnt=2: commit and pe_done on EP0 in the same cycle -> ack, cnt stays 2.
//    The bank order remains correct on read-back.
//  5 EP3: commit len=1023 -> pe_pkt_len=512. Commit len=0 -> ZLP reported with len 0.
//  6 EP1 cnt=1, ep_flush=4'b0010 with a simultaneous commit on EP1 -> no ack and no err,
//    pe_has_pkt[1]=0. Other endpoints are unchanged.

Source files
------------

// File: rtl/usb_in_ep_pingpong_buf.sv
// Multi-endpoint ping-pong IN packet buffer between the app write port
// and the USB protocol engine; packets are held until the host ACKs them.
module usb_in_ep_pingpong_buf #(
    parameter int NUM_EP = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 10,
    localparam int EPW   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic              phy_ulpi_clk,
    input  logic              reset_n,
    input  logic [EPW-1:0]    buf_in_ep,
    input  logic [ADDR_W-1:0] buf_in_addr,
    input  logic [DATA_W-1:0] buf_in_data,
    input  logic              buf_in_wren,
    input  logic              buf_in_commit,
    input  logic [LEN_W-1:0]  buf_in_commit_len,
    output logic [NUM_EP-1:0] buf_in_ready,
    output logic              buf_in_commit_ack,
    output logic              err_commit_ovf,
    input  logic [EPW-1:0]    pe_rd_ep,
    input  logic [ADDR_W-1:0] pe_rd_addr,
    output logic [DATA_W-1:0] pe_rd_data,
    output logic [NUM_EP-1:0] pe_has_pkt,
    output logic [LEN_W-1:0]  pe_pkt_len,
    input  logic              pe_done,
    input  logic [NUM_EP-1:0] ep_flush
);

    localparam int RAW   = EPW + 1 + ADDR_W;
    localparam int DEPTH = NUM_EP * 2 * (2 ** ADDR_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [2*NUM_EP-1:0]     cnt_v;
    logic [NUM_EP-1:0]       wb_v;
    logic [NUM_EP-1:0]       rb_v;
    logic [LEN_W*NUM_EP-1:0] len0_v;
    logic [LEN_W*NUM_EP-1:0] len1_v;

    logic              in_ok;
    logic              rd_ok;
    logic [NUM_EP-1:0] in_sel;
    logic [NUM_EP-1:0] rd_sel;
    logic              in_flush;
    logic              rd_flush;
    logic [1:0]        in_cnt;
    logic [1:0]        rd_cnt;
    logic              in_wb;
    logic              rd_rb;
    logic [LEN_W-1:0]  rd_len;
    logic              wr_en;
    logic              commit_hit;
    logic              commit_acc;
    logic              done_acc;
    logic [LEN_W-1:0]  len_sat;
    logic [RAW-1:0]    wr_addr;
    logic [RAW-1:0]    rd_addr;

    assign in_ok = 32'(buf_in_ep) < NUM_EP;
    assign rd_ok = 32'(pe_rd_ep) < NUM_EP;

    // One-hot selects keep every per-endpoint lookup in range
    always_comb begin
        in_sel = '0;
        rd_sel = '0;
        in_cnt = '0;
        rd_cnt = '0;
        in_wb  = 1'b0;
        rd_rb  = 1'b0;
        rd_len = '0;
        for (int e = 0; e < NUM_EP; e++) begin
            in_sel[e] = in_ok && (buf_in_ep == EPW'(e));
            rd_sel[e] = rd_ok && (pe_rd_ep == EPW'(e));
            if (in_sel[e]) begin
                in_cnt = cnt_v[2*e +: 2];
                in_wb  = wb_v[e];
            end
            if (rd_sel[e]) begin
                rd_cnt = cnt_v[2*e +: 2];
                rd_rb  = rb_v[e];
                rd_len = rb_v[e] ? len1_v[LEN_W*e +: LEN_W]
                                 : len0_v[LEN_W*e +: LEN_W];
            end
        end
    end

    assign in_flush = |(in_sel & ep_flush);
    assign rd_flush = |(rd_sel & ep_flush);

    assign commit_hit = buf_in_commit && in_ok && !in_flush;
    assign done_acc   = pe_done && rd_ok && !rd_flush
                        && (rd_cnt != 2'd0);
    // A full endpoint still accepts if its head is released this cycle
    assign commit_acc = commit_hit
                        && ((in_cnt != 2'd2)
                            || (done_acc && (in_sel == rd_sel)));

    assign wr_en = buf_in_wren && in_ok && !in_flush
                   && (in_cnt != 2'd2);

    assign len_sat = (buf_in_commit_len > LEN_MAX) ? LEN_MAX
                                                   : buf_in_commit_len;

    assign wr_addr = {buf_in_ep, in_wb, buf_in_addr};
    assign rd_addr = {pe_rd_ep, rd_rb, pe_rd_addr};

    assign pe_pkt_len = (rd_cnt != 2'd0) ? rd_len : '0;

    always_ff @(posedge phy_ulpi_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= buf_in_data;
        end
    end

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            pe_rd_data <= '0;
        end else if (rd_ok) begin
            pe_rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_in_commit_ack <= 1'b0;
            err_commit_ovf    <= 1'b0;
        end else begin
            buf_in_commit_ack <= commit_acc;
            err_commit_ovf    <= commit_hit && !commit_acc;
        end
    end

    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        logic [1:0]       cnt_q;
        logic             wb_q;
        logic             rb_q;
        logic [LEN_W-1:0] len0_q;
        logic [LEN_W-1:0] len1_q;
        logic             c;
        logic             d;

        assign c = commit_acc && in_sel[g];
        assign d = done_acc && rd_sel[g];

        always_ff @(posedge phy_ulpi_clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q  <= 2'd0;
                wb_q   <= 1'b0;
                rb_q   <= 1'b0;
                len0_q <= '0;
                len1_q <= '0;
            end else if (ep_flush[g]) begin
                cnt_q <= 2'd0;
                wb_q  <= 1'b0;
                rb_q  <= 1'b0;
            end else begin
                if (c) begin
                    if (wb_q) begin
                        len1_q <= len_sat;
                    end else begin
                        len0_q <= len_sat;
                    end
                    wb_q <= ~wb_q;
                end
                if (d) begin
                    rb_q <= ~rb_q;
                end
                unique case ({c, d})
                    2'b10:   cnt_q <= cnt_q + 2'd1;
                    2'b01:   cnt_q <= cnt_q - 2'd1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign cnt_v[2*g +: 2]          = cnt_q;
        assign wb_v[g]                  = wb_q;
        assign rb_v[g]                  = rb_q;
        assign len0_v[LEN_W*g +: LEN_W] = len0_q;
        assign len1_v[LEN_W*g +: LEN_W] = len1_q;
        assign buf_in_ready[g]          = (cnt_q != 2'd2);
        assign pe_has_pkt[g]            = (cnt_q != 2'd0);
    end

endmodule

// File: tb/tb_usb_in_ep_pingpong_buf.sv
// Bench for usb_in_ep_pingpong_buf: directed vector table plus
// randomized traffic against a packet-queue reference model.
module tb_usb_in_ep_pingpong_buf;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] buf_in_ep;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       buf_in_commit;
    logic [9:0] buf_in_commit_len;
    logic [3:0] buf_in_ready;
    logic       buf_in_commit_ack;
    logic       err_commit_ovf;
    logic [1:0] pe_rd_ep;
    logic [8:0] pe_rd_addr;
    logic [7:0] pe_rd_data;
    logic [3:0] pe_has_pkt;
    logic [9:0] pe_pkt_len;
    logic       pe_done;
    logic [3:0] ep_flush;

    always #5 clk = ~clk;

    usb_in_ep_pingpong_buf dut (
        .phy_ulpi_clk      (clk),
        .reset_n           (reset_n),
        .buf_in_ep         (buf_in_ep),
        .buf_in_addr       (buf_in_addr),
        .buf_in_data       (buf_in_data),
        .buf_in_wren       (buf_in_wren),
        .buf_in_commit     (buf_in_commit),
        .buf_in_commit_len (buf_in_commit_len),
        .buf_in_ready      (buf_in_ready),
        .buf_in_commit_ack (buf_in_commit_ack),
        .err_commit_ovf    (err_commit_ovf),
        .pe_rd_ep          (pe_rd_ep),
        .pe_rd_addr        (pe_rd_addr),
        .pe_rd_data        (pe_rd_data),
        .pe_has_pkt        (pe_has_pkt),
        .pe_pkt_len        (pe_pkt_len),
        .pe_done           (pe_done),
        .ep_flush          (ep_flush)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: per endpoint a FIFO of at most two packets,
    // plus the bytes written to the packet currently being filled.
    typedef struct packed {
        logic [9:0]  len;
        logic [63:0] bytes;
        logic [7:0]  vm;
    } pkt_t;

    pkt_t        mq [4][2];
    int          mn [4];
    logic [63:0] ib [4];
    logic [7:0]  iv [4];

    function automatic logic [9:0] sat(logic [9:0] l);
        return (l > 10'd512) ? 10'd512 : l;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 4; e++) begin
            mn[e] = 0;
            iv[e] = '0;
            ib[e] = '0;
        end
    endtask

    task automatic idle();
        buf_in_ep = 2'd0;
        buf_in_addr = 9'd0;
        buf_in_data = 8'd0;
        buf_in_wren = 1'b0;
        buf_in_commit = 1'b0;
        buf_in_commit_len = 10'd0;
        pe_rd_ep = 2'd0;
        pe_rd_addr = 9'd0;
        pe_done = 1'b0;
        ep_flush = 4'd0;
    endtask

    // One clock with the inputs already applied; model checked both sides
    task automatic cyc();
        logic eack;
        logic eovf;
        logic rchk;
        logic dfire;
        logic cfire;
        logic [7:0] rexp;
        logic [9:0] pexp;
        logic [3:0] erdy;
        logic [3:0] ehas;
        int ce;
        int de;
        int ra;
        int wa;
        ce = int'(buf_in_ep);
        de = int'(pe_rd_ep);
        ra = int'(pe_rd_addr[2:0]);
        wa = int'(buf_in_addr[2:0]);
        #1;
        pexp = (mn[de] > 0) ? mq[de][0].len : 10'd0;
        chk("pkt_len_pre", 32'(pe_pkt_len), 32'(pexp));
        rchk = (mn[de] > 0) && (pe_rd_addr < 9'd8) && mq[de][0].vm[ra];
        rexp = mq[de][0].bytes[ra*8 +: 8];
        dfire = pe_done && !ep_flush[de] && (mn[de] > 0);
        cfire = buf_in_commit && !ep_flush[ce]
                && ((mn[ce] < 2) || (dfire && (de == ce)));
        eack = cfire;
        eovf = buf_in_commit && !ep_flush[ce] && !cfire;
        if (buf_in_wren && !ep_flush[ce] && (mn[ce] < 2)
            && (buf_in_addr < 9'd8)) begin
            ib[ce][wa*8 +: 8] = buf_in_data;
            iv[ce][wa] = 1'b1;
        end
        if (dfire) begin
            mq[de][0] = mq[de][1];
            mn[de]--;
        end
        if (cfire) begin
            mq[ce][mn[ce]].len = sat(buf_in_commit_len);
            mq[ce][mn[ce]].bytes = ib[ce];
            mq[ce][mn[ce]].vm = iv[ce];
            mn[ce]++;
            iv[ce] = '0;
        end
        for (int e = 0; e < 4; e++) begin
            if (ep_flush[e]) begin
                mn[e] = 0;
                iv[e] = '0;
            end
        end
        for (int e = 0; e < 4; e++) begin
            erdy[e] = (mn[e] != 2);
            ehas[e] = (mn[e] != 0);
        end
        @(posedge clk);
        #1;
        chk("ack", 32'(buf_in_commit_ack), 32'(eack));
        chk("ovf", 32'(err_commit_ovf), 32'(eovf));
        chk("ready", 32'(buf_in_ready), 32'(erdy));
        chk("has_pkt", 32'(pe_has_pkt), 32'(ehas));
        if (rchk) begin
            chk("rd_data", 32'(pe_rd_data), 32'(rexp));
        end
    endtask

    typedef struct {
        logic [1:0] ep;
        logic       wren;
        logic [8:0] addr;
        logic [7:0] data;
        logic       commit;
        logic [9:0] len;
        logic [1:0] rep;
        logic [8:0] raddr;
        logic       done;
        logic [3:0] flush;
        logic       ack;
        logic       ovf;
        logic [3:0] rdy;
        logic [3:0] has;
        logic [9:0] plen;
        logic       rchk;
        logic [7:0] rdat;
    } vec_t;

    function automatic vec_t mk(
        logic [1:0] ep, logic wren, logic [8:0] addr, logic [7:0] data,
        logic commit, logic [9:0] len, logic [1:0] rep,
        logic [8:0] raddr, logic done, logic [3:0] flush,
        logic ack, logic ovf, logic [3:0] rdy, logic [3:0] has,
        logic [9:0] plen, logic rchk, logic [7:0] rdat);
        vec_t v;
        v.ep = ep; v.wren = wren; v.addr = addr; v.data = data;
        v.commit = commit; v.len = len; v.rep = rep;
        v.raddr = raddr; v.done = done; v.flush = flush;
        v.ack = ack; v.ovf = ovf; v.rdy = rdy; v.has = has;
        v.plen = plen; v.rchk = rchk; v.rdat = rdat;
        return v;
    endfunction

    vec_t tbl[$];
    logic [3:0] fl;
    int r;

    initial begin
        // ep wr addr data  cm len   rep raddr dn flush | ack ovf rdy has plen rchk rdat
        tbl.push_back(mk(1, 0, 0, 0,    1, 64,   1, 5, 0, 0, 1, 0, 4'hF, 4'h2, 64,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    1, 5, 0, 0, 0, 0, 4'hF, 4'h2, 64,  1, 8'h05));
        tbl.push_back(mk(2, 0, 0, 0,    1, 10,   2, 0, 0, 0, 1, 0, 4'hF, 4'h6, 10,  0, 0));
        tbl.push_back(mk(2, 0, 0, 0,    1, 20,   2, 0, 0, 0, 1, 0, 4'hB, 4'h6, 10,  0, 0));
        tbl.push_back(mk(2, 0, 0, 0,    1, 30,   2, 0, 0, 0, 0, 1, 4'hB, 4'h6, 10,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 1, 0, 0, 0, 4'hF, 4'h6, 20,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    2, 0, 1, 0, 0, 0, 4'hF, 4'h2, 0,   0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hA0, 1, 1,   0, 0, 0, 0, 1, 0, 4'hF, 4'h3, 1,   0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hB0, 1, 2,   0, 0, 0, 0, 1, 0, 4'hE, 4'h3, 1,   1, 8'hA0));
        tbl.push_back(mk(0, 1, 0, 8'hC0, 1, 3,   0, 0, 1, 0, 1, 0, 4'hE, 4'h3, 2,   1, 8'hA0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 0, 0, 4'hE, 4'h3, 2,   1, 8'hB0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 1, 0, 0, 0, 4'hF, 4'h3, 3,   1, 8'hB0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 0, 0, 0, 0, 4'hF, 4'h3, 3,   1, 8'hA0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    0, 0, 1, 0, 0, 0, 4'hF, 4'h2, 0,   1, 8'hA0));
        tbl.push_back(mk(3, 0, 0, 0,    1, 1023, 3, 0, 0, 0, 1, 0, 4'hF, 4'hA, 512, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0,    1, 0,    3, 0, 0, 0, 1, 0, 4'h7, 4'hA, 512, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    3, 0, 1, 0, 0, 0, 4'hF, 4'hA, 0,   0, 0));
        tbl.push_back(mk(3, 0, 0, 0,    1, 513,  3, 0, 1, 0, 1, 0, 4'hF, 4'hA, 512, 0, 0));
        tbl.push_back(mk(3, 0, 0, 0,    1, 512,  3, 0, 0, 0, 1, 0, 4'h7, 4'hA, 512, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,    1, 9,    1, 0, 0, 2, 0, 0, 4'h7, 4'h8, 0,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    3, 0, 0, 0, 0, 0, 4'h7, 4'h8, 512, 0, 0));
        tbl.push_back(mk(1, 1, 2, 8'h5A, 1, 4,   1, 0, 0, 0, 1, 0, 4'h7, 4'hA, 4,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0,    0, 0,    1, 2, 0, 0, 0, 0, 4'h7, 4'hA, 4,   1, 8'h5A));

        reset_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(buf_in_ready), 32'h0000000F);
        chk("rst_has_pkt", 32'(pe_has_pkt), 32'h0);
        chk("rst_pkt_len", 32'(pe_pkt_len), 32'h0);
        chk("rst_ack", 32'(buf_in_commit_ack), 32'h0);
        chk("rst_ovf", 32'(err_commit_ovf), 32'h0);
        chk("rst_rd_data", 32'(pe_rd_data), 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 64; a++) begin
            idle();
            buf_in_ep = 2'd1;
            buf_in_wren = 1'b1;
            buf_in_addr = 9'(a);
            buf_in_data = 8'(a);
            cyc();
        end

        for (int i = 0; i < tbl.size(); i++) begin
            buf_in_ep = tbl[i].ep;
            buf_in_wren = tbl[i].wren;
            buf_in_addr = tbl[i].addr;
            buf_in_data = tbl[i].data;
            buf_in_commit = tbl[i].commit;
            buf_in_commit_len = tbl[i].len;
            pe_rd_ep = tbl[i].rep;
            pe_rd_addr = tbl[i].raddr;
            pe_done = tbl[i].done;
            ep_flush = tbl[i].flush;
            cyc();
            chk($sformatf("v%0d_ack", i), 32'(buf_in_commit_ack), 32'(tbl[i].ack));
            chk($sformatf("v%0d_ovf", i), 32'(err_commit_ovf), 32'(tbl[i].ovf));
            chk($sformatf("v%0d_rdy", i), 32'(buf_in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_has", i), 32'(pe_has_pkt), 32'(tbl[i].has));
            chk($sformatf("v%0d_plen", i), 32'(pe_pkt_len), 32'(tbl[i].plen));
            if (tbl[i].rchk) begin
                chk($sformatf("v%0d_rdat", i), 32'(pe_rd_data), 32'(tbl[i].rdat));
            end
        end

        for (int n = 0; n < 800; n++) begin
            buf_in_ep = 2'($urandom_range(0, 3));
            buf_in_wren = 1'($urandom_range(0, 1));
            buf_in_addr = 9'($urandom_range(0, 7));
            buf_in_data = 8'($urandom);
            buf_in_commit = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            case (r)
                0: buf_in_commit_len = 10'd0;
                1: buf_in_commit_len = 10'd512;
                2: buf_in_commit_len = 10'd513;
                3: buf_in_commit_len = 10'd1023;
                default: buf_in_commit_len = 10'($urandom_range(1, 511));
            endcase
            pe_rd_ep = 2'($urandom_range(0, 3));
            pe_rd_addr = 9'($urandom_range(0, 7));
            pe_done = ($urandom_range(0, 3) == 0);
            fl = 4'd0;
            if ($urandom_range(0, 24) == 0) begin
                fl[$urandom_range(0, 3)] = 1'b1;
            end
            ep_flush = fl;
            cyc();
        end

        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(buf_in_ready), 32'h0000000F);
        chk("arst_has_pkt", 32'(pe_has_pkt), 32'h0);
        chk("arst_pkt_len", 32'(pe_pkt_len), 32'h0);
        chk("arst_rd_data", 32'(pe_rd_data), 32'h0);
        @(posedge clk);
        #1;
        chk("arst_ack", 32'(buf_in_commit_ack), 32'h0);
        reset_n = 1'b1;
        model_reset();

        for (int n = 0; n < 100; n++) begin
            buf_in_ep = 2'($urandom_range(0, 3));
            buf_in_wren = 1'($urandom_range(0, 1));
            buf_in_addr = 9'($urandom_range(0, 7));
            buf_in_data = 8'($urandom);
            buf_in_commit = ($urandom_range(0, 1) == 0);
            buf_in_commit_len = 10'($urandom_range(0, 1023));
            pe_rd_ep = 2'($urandom_range(0, 3));
            pe_rd_addr = 9'($urandom_range(0, 7));
            pe_done = ($urandom_range(0, 3) == 0);
            ep_flush = 4'd0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
